regfile_port_arbiter: RTL

//  Shares one single-port register file between two requesters (e.g. fetch/decode and execute/writeback).
//  - Per-requester valid/ready request channel and valid/ready response channel.
//  - Round-robin arbitration.
//  - Sequences each access as ACCEPT -> ACCESS -> RESPOND.
//  - Sits directly in front of the register file and owns its reg/in/we/oe inputs.

---
 rtl/regfile_port_arbiter_pkg.sv | 16 +
 rtl/regfile_port_arbiter_rr_pick2.sv | 13 +
 rtl/regfile_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types for the two-requester register-file port arbiter.
package regfile_port_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the requester that was not served last wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one single-port register file between two requesters (ACCEPT -> ACCESS -> RESP).
// Optional REGFILE_ARB_LOCK_EN adds i_w_lock for read-modify-write ownership of the port.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int p_data_width    = 5,
    parameter int p_address_width = 3
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_reset,
    input  logic [1:0]                   i_w_req_valid,
    output logic [1:0]                   o_w_req_ready,
    input  logic [1:0]                   i_w_req_we,
    input  logic [2*p_address_width-1:0] i_w_req_reg,
    input  logic [2*p_data_width-1:0]    i_w_req_data,
    output logic [1:0]                   o_w_rsp_valid,
    input  logic [1:0]                   i_w_rsp_ready,
    output logic [p_data_width-1:0]      o_w_rsp_data,
    output logic [p_address_width-1:0]   o_w_rf_reg,
    output logic [p_data_width-1:0]      o_w_rf_in,
    output logic                         o_w_rf_we,
    output logic                         o_w_rf_oe,
    input  logic [p_data_width-1:0]      i_w_rf_out,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [1:0]                   i_w_lock,
`endif
    output logic                         o_w_busy
);

    localparam int AW = p_address_width;
    localparam int DW = p_data_width;

    state_t          state;
    logic            last;
    logic            cur;
    logic [1:0]      eligible;
    logic [1:0]      grant;
    logic            pick;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;

`ifdef REGFILE_ARB_LOCK_EN
    logic locked;
    logic lock_owner;

    // While locked only the owner may be accepted, regardless of round-robin order.
    assign eligible = locked ? (i_w_req_valid & onehot2(lock_owner)) : i_w_req_valid;
`else
    assign eligible = i_w_req_valid;
`endif

    rr_pick2 u_pick (
        .valid (eligible),
        .last  (last),
        .grant (grant)
    );

    assign pick     = grant[1];
    assign sel_reg  = pick ? i_w_req_reg[2*AW-1:AW]  : i_w_req_reg[AW-1:0];
    assign sel_data = pick ? i_w_req_data[2*DW-1:DW] : i_w_req_data[DW-1:0];

    // Acceptance is the only combinational output; reset forces it low too.
    assign o_w_req_ready = (state == IDLE && !i_w_reset) ? grant : 2'b00;

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state         <= IDLE;
            last          <= 1'b1;
            cur           <= 1'b0;
            o_w_rsp_valid <= '0;
            o_w_rsp_data  <= '0;
            o_w_rf_reg    <= '0;
            o_w_rf_in     <= '0;
            o_w_rf_we     <= 1'b0;
            o_w_rf_oe     <= 1'b0;
            o_w_busy      <= 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
            locked        <= 1'b0;
            lock_owner    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cur        <= pick;
                        last       <= pick;
                        o_w_rf_reg <= sel_reg;
                        o_w_rf_we  <= i_w_req_we[pick];
                        o_w_rf_oe  <= ~i_w_req_we[pick];
                        o_w_rf_in  <= i_w_req_we[pick] ? sel_data : '0;
                        o_w_busy   <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write acks carry zero data.
                    o_w_rsp_data  <= o_w_rf_oe ? i_w_rf_out : '0;
                    o_w_rsp_valid <= onehot2(cur);
                    o_w_rf_reg    <= '0;
                    o_w_rf_in     <= '0;
                    o_w_rf_we     <= 1'b0;
                    o_w_rf_oe     <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (i_w_rsp_ready[cur]) begin
                        o_w_rsp_valid <= '0;
                        o_w_rsp_data  <= '0;
                        o_w_busy      <= 1'b0;
                        state         <= IDLE;
`ifdef REGFILE_ARB_LOCK_EN
                        locked        <= i_w_lock[cur];
                        lock_owner    <= cur;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
